fifo_sync_flags: RTL
====================

// Module: fifo_sync_flags
// PURPOSE
//  Parametrised synchronous first-word-fall-through FIFO; next generation of the basic primitive FIFO.
//  Adds an occupancy count, programmable almost-full/almost-empty thresholds and a synchronous flush.
//  Used as a buffer in peripheral datapaths (UART RX/TX, bus bridges) in rtl/primitives.
// PARAMETERS
//  XLEN        32  data word width in bits (>=1)
//  LENGTH      4   depth in entries; power of two, >=2
//  AFULL_TH    3   almost_full asserted when count >= AFULL_TH (1..LENGTH)
//  AEMPTY_TH   1   almost_empty asserted when count <= AEMPTY_TH (0..LENGTH-1)
// PORTS
//  clk          in   1                     clock, all state changes on rising edge
//  reset        in   1                     asynchronous, active-low reset
//  flush        in   1                     synchronous clear of contents
//  we           in   1                     write enable
//  di           in   XLEN                  write data
//  re           in   1                     read enable (pop)
//  do           out  XLEN                  front entry, valid whenever empty==0
//  empty        out  1                     no entries held
//  full         out  1                     LENGTH entries held
//  almost_empty out  1                     count <= AEMPTY_TH
//  almost_full  out  1                     count >= AFULL_TH
//  count        out  $clog2(LENGTH)+1      entries held, 0..LENGTH
//  overflow     out  1                     (FIFO_ERR_FLAGS_EN only) sticky: write refused
//  underflow    out  1                     (FIFO_ERR_FLAGS_EN only) sticky: read refused
//  err_clr      in   1                     (FIFO_ERR_FLAGS_EN only) clears both sticky flags
// BEHAVIOUR
//  - State: storage[LENGTH], frontPointer, backPointer ($clog2(LENGTH) bits, wrap mod LENGTH), count.
//  - reset low (async): pointers=0, count=0 -> empty=1, full=0, almost_empty=1, almost_full=0,
//    overflow=underflow=0. Storage not cleared. Release takes effect on next clk edge.
//  - Flags are combinational decodes of count only; updated the cycle after the causing edge.
//  - do = storage[frontPointer], combinational (FWFT, zero read latency); undefined when empty.
//  - Effective write: we & (~full | re). Effective read: re & ~empty.
//  - Write: storage[backPointer]<=di, backPointer+1. Read: frontPointer+1.
//  - count: +1 write only, -1 read only, unchanged for both or neither.
//  - Full & we & re: both performed (pop front, push di); count stays LENGTH.
//  - Empty & we & re: write only, read ignored (no bypass); count becomes 1.
//  - Full & we & ~re: write ignored, pointers unchanged. Empty & re & ~we: read ignored.
//  - Pointer wrap: LENGTH-1 -> 0 on increment, no special casing.
//  - flush=1 at edge: pointers=0, count=0; overrides we/re in that cycle (no write captured).
//  - Reset asserted mid-operation: state cleared immediately regardless of clk/we/re.
// CONFIGURATION
//  - FIFO_ERR_FLAGS_EN defined: overflow sets on we & full & ~re & ~flush; underflow sets on
//    re & empty & ~flush; both sticky until err_clr=1 at an edge (set wins if same cycle);
//    cleared by reset. Ports overflow, underflow, err_clr exist.
//  - FIFO_ERR_FLAGS_EN undefined: those three ports and the sticky logic are absent.
// TESTING (XLEN=32, LENGTH=4, AFULL_TH=3, AEMPTY_TH=1)
//  - Reset: reset=0 two cycles -> empty=1 full=0 count=0 almost_empty=1 almost_full=0;
//    re=1 on empty -> pointers stay 0, count=0 (underflow=1 if FIFO_ERR_FLAGS_EN).
//  - Fill: write 0xdeadbeef,0xbababebe,0xcacacaca,0xfeedbeef -> count 1,2,3,4;
//    almost_empty drops at count=2, almost_full at count=3, full at 4; backPointer wraps to 0.
//  - Full write: we=1 di=0 with full -> count=4, backPointer=0, do=0xdeadbeef
//    (overflow=1 if enabled; err_clr=1 one cycle -> overflow=0).
//  - Drain in order: re=1 -> do 0xdeadbeef,0xbababebe,0xcacacaca,0xfeedbeef each cycle, then empty=1.
//  - Simultaneous: full + we=re=1 di=0x01010101 -> count=4, next do=0xbababebe; empty + we=re=1
//    di=0x02020202 -> count=1, do=0x02020202.
//  - Flush/async reset: 3 entries, flush=1 with we=1 -> count=0 empty=1; refill 2, pulse reset=0
//    between edges -> count=0 empty=1 immediately, before next clk edge.

Source files
------------

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: synchronous first-word-fall-through FIFO with occupancy
// count, almost-full/almost-empty thresholds and a synchronous flush.
// The front entry is presented on dout with zero read latency.
// Optional build macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// flags and their err_clr input.
module fifo_sync_flags #(
  parameter int XLEN      = 32,
  parameter int LENGTH    = 4,
  parameter int AFULL_TH  = 3,
  parameter int AEMPTY_TH = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      we,
  input  logic [XLEN-1:0]           di,
  input  logic                      re,
  output logic [XLEN-1:0]           dout,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_empty,
  output logic                      almost_full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                      overflow,
  output logic                      underflow,
  input  logic                      err_clr,
`endif
  output logic [$clog2(LENGTH):0]   count
);

  localparam int PW = $clog2(LENGTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] storage [LENGTH];
  logic [PW-1:0]   front_ptr;
  logic [PW-1:0]   back_ptr;
  logic            wr_en;
  logic            rd_en;

  // A write into a full FIFO is accepted only when a pop frees a slot in the
  // same cycle; a read of an empty FIFO is never honoured (no bypass).
  assign wr_en = we & (~full | re);
  assign rd_en = re & ~empty;

  // Status flags are pure decodes of the occupancy count.
  assign empty        = (count == '0);
  assign full         = (count == CW'(LENGTH));
  assign almost_empty = (count <= CW'(AEMPTY_TH));
  assign almost_full  = (count >= CW'(AFULL_TH));

  // Front entry falls through combinationally.
  assign dout = storage[front_ptr];

  // Pointer and occupancy bookkeeping; flush wins over any write/read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      front_ptr <= '0;
      back_ptr  <= '0;
      count     <= '0;
    end else if (flush) begin
      front_ptr <= '0;
      back_ptr  <= '0;
      count     <= '0;
    end else begin
      if (wr_en) back_ptr  <= back_ptr + PW'(1);
      if (rd_en) front_ptr <= front_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage carries no reset; only accepted writes land in it.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) storage[back_ptr] <= di;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_set;
  logic unf_set;

  assign ovf_set = we & full & ~re & ~flush;
  assign unf_set = re & empty & ~flush;

  // Sticky error flags: a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (unf_set)      underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end
`endif

endmodule
